// File: rtl/atm_controller_param.sv
// atm_controller_param
//   Parametrised single-account ATM transaction controller. Detects a card,
//   collects a BCD PIN, checks it against PIN_CODE with a bounded attempt
//   counter (warning one attempt before lockout), then runs one deposit or
//   withdrawal with saturating / funds-checked arithmetic. Idle sessions are
//   aborted after TIMEOUT_CYC cycles. All outputs are registered.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   tarjeta_recibida      card present (level), only looked at in IDLE
//   tipo_trans            0 = deposit, 1 = withdrawal, sampled in CHECK
//   digito_stb, digito    one-cycle strobe with a BCD keypad digit
//   monto_stb, monto      one-cycle strobe with the transaction amount
//   balance_actualizado   pulse: balance register changed (or zero withdrawal)
//   entregar_dinero       pulse: dispense cash
//   pin_incorrecto        pulse: PIN compare failed
//   advertencia           level: one PIN attempt left
//   bloqueo               level: account locked until rst
//   fondos_insuficientes  pulse: withdrawal rejected
//   balance               current balance
//   estado                current state code (IDLE=0 .. BLOCKED=5)

module atm_controller_param #(
  parameter int unsigned             PIN_DIGITS   = 4,
  parameter logic [PIN_DIGITS*4-1:0] PIN_CODE     = (PIN_DIGITS*4)'(16'h4756),
  parameter int unsigned             MAX_ATTEMPTS = 3,
  parameter int unsigned             BAL_W        = 64,
  parameter int unsigned             MONTO_W      = 32,
  parameter logic [BAL_W-1:0]        INIT_BALANCE = BAL_W'(4500),
  parameter int unsigned             TIMEOUT_CYC  = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tarjeta_recibida,
  input  logic               tipo_trans,
  input  logic               digito_stb,
  input  logic [3:0]         digito,
  input  logic               monto_stb,
  input  logic [MONTO_W-1:0] monto,
  output logic               balance_actualizado,
  output logic               entregar_dinero,
  output logic               pin_incorrecto,
  output logic               advertencia,
  output logic               bloqueo,
  output logic               fondos_insuficientes,
  output logic [BAL_W-1:0]   balance,
  output logic [2:0]         estado
);

  localparam int unsigned PW     = PIN_DIGITS * 4;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ATT_W  = 3;
  localparam int unsigned TMO_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(PIN_DIGITS);
  localparam logic [ATT_W-1:0] ATT_MAX  = ATT_W'(MAX_ATTEMPTS);
  localparam logic [ATT_W-1:0] ATT_WARN = ATT_W'(MAX_ATTEMPTS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PIN      = 3'd1,
    S_CHECK    = 3'd2,
    S_DEPOSIT  = 3'd3,
    S_WITHDRAW = 3'd4,
    S_BLOCKED  = 3'd5
  } state_t;

  state_t             state_r,   state_nx;
  logic [BAL_W-1:0]   balance_r, balance_nx;
  logic [ATT_W-1:0]   att_r,     att_nx;
  logic [CNT_W-1:0]   cnt_r,     cnt_nx;
  logic [PW-1:0]      pin_r,     pin_nx;
  logic [TMO_W-1:0]   tmo_r,     tmo_nx;
  logic               warn_r,    warn_nx;
  logic               lock_r,    lock_nx;
  logic               upd_r,     upd_nx;
  logic               disp_r,    disp_nx;
  logic               bad_r,     bad_nx;
  logic               nsf_r,     nsf_nx;

  logic [PW-1:0]      pin_shift;
  logic [BAL_W-1:0]   monto_b;
  logic [BAL_W:0]     sum;
  logic [ATT_W-1:0]   att_inc;
  logic               any_stb;
  logic               in_session;
  logic               timed_out;

  // New digit enters at the LSBs so the first-entered digit ends up on top.
  always_comb begin
    pin_shift      = pin_r << 4;
    pin_shift[3:0] = digito;
  end

  assign monto_b    = BAL_W'(monto);
  assign sum        = {1'b0, balance_r} + {1'b0, monto_b};
  assign att_inc    = att_r + ATT_W'(1);
  assign any_stb    = digito_stb | monto_stb;
  assign in_session = (state_r == S_PIN) || (state_r == S_DEPOSIT) ||
                      (state_r == S_WITHDRAW);
  // A strobe arriving on the last idle cycle still counts as activity.
  assign timed_out  = (tmo_r == TMO_LAST) && !any_stb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      balance_r <= INIT_BALANCE;
      att_r     <= '0;
      cnt_r     <= '0;
      pin_r     <= '0;
      tmo_r     <= '0;
      warn_r    <= 1'b0;
      lock_r    <= 1'b0;
      upd_r     <= 1'b0;
      disp_r    <= 1'b0;
      bad_r     <= 1'b0;
      nsf_r     <= 1'b0;
    end else begin
      state_r   <= state_nx;
      balance_r <= balance_nx;
      att_r     <= att_nx;
      cnt_r     <= cnt_nx;
      pin_r     <= pin_nx;
      tmo_r     <= tmo_nx;
      warn_r    <= warn_nx;
      lock_r    <= lock_nx;
      upd_r     <= upd_nx;
      disp_r    <= disp_nx;
      bad_r     <= bad_nx;
      nsf_r     <= nsf_nx;
    end
  end

  always_comb begin
    state_nx   = state_r;
    balance_nx = balance_r;
    att_nx     = att_r;
    cnt_nx     = cnt_r;
    pin_nx     = pin_r;
    tmo_nx     = '0;
    warn_nx    = warn_r;
    lock_nx    = lock_r;
    upd_nx     = 1'b0;
    disp_nx    = 1'b0;
    bad_nx     = 1'b0;
    nsf_nx     = 1'b0;

    case (state_r)
      S_IDLE: begin
        if (tarjeta_recibida) begin
          state_nx = S_PIN;
          cnt_nx   = '0;
          pin_nx   = '0;
        end
      end

      S_PIN: begin
        // A full PIN wins over any strobe arriving in the same cycle.
        if (cnt_r == DIG_LAST) begin
          state_nx = S_CHECK;
        end else if (digito_stb) begin
          pin_nx = pin_shift;
          cnt_nx = cnt_r + CNT_W'(1);
        end else if (timed_out) begin
          state_nx = S_IDLE;
        end
      end

      S_CHECK: begin
        if (pin_r == PIN_CODE) begin
          att_nx   = '0;
          warn_nx  = 1'b0;
          state_nx = tipo_trans ? S_WITHDRAW : S_DEPOSIT;
        end else begin
          att_nx = att_inc;
          bad_nx = 1'b1;
          cnt_nx = '0;
          pin_nx = '0;
          if (att_inc == ATT_MAX) begin
            state_nx = S_BLOCKED;
            lock_nx  = 1'b1;
            warn_nx  = 1'b0;
          end else begin
            state_nx = S_PIN;
            if (att_inc == ATT_WARN) warn_nx = 1'b1;
          end
        end
      end

      S_DEPOSIT: begin
        if (monto_stb) begin
          // Carry out of the widened add means the balance would wrap.
          balance_nx = sum[BAL_W] ? '1 : sum[BAL_W-1:0];
          upd_nx     = 1'b1;
          state_nx   = S_IDLE;
        end else if (timed_out) begin
          state_nx = S_IDLE;
        end
      end

      S_WITHDRAW: begin
        if (monto_stb) begin
          if (monto_b > balance_r) begin
            nsf_nx = 1'b1;
          end else begin
            balance_nx = balance_r - monto_b;
            disp_nx    = 1'b1;
            upd_nx     = 1'b1;
          end
          state_nx = S_IDLE;
        end else if (timed_out) begin
          state_nx = S_IDLE;
        end
      end

      S_BLOCKED: begin
        // Absorbing: only rst leaves this state.
        lock_nx = 1'b1;
        warn_nx = 1'b0;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase

    // Idle timer runs only while a session state is held with no strobe.
    if (in_session && (state_nx == state_r) && !any_stb) begin
      tmo_nx = tmo_r + TMO_W'(1);
    end
  end

  assign balance_actualizado  = upd_r;
  assign entregar_dinero      = disp_r;
  assign pin_incorrecto       = bad_r;
  assign advertencia          = warn_r;
  assign bloqueo              = lock_r;
  assign fondos_insuficientes = nsf_r;
  assign balance              = balance_r;
  assign estado               = state_r;

endmodule

// File: tb/tb_atm_controller_param.sv
// tb_atm_controller_param
//   Self-checking bench for atm_controller_param (16-bit balance, 16-cycle
//   timeout). Directed scenarios followed by randomized sessions, each checked
//   against a session-level model of balance, attempt count and lockout.

module tb_atm_controller_param;

  localparam logic [15:0] PIN_OK = 16'h4756;
  localparam int          MAXA   = 3;
  localparam longint      BAL0   = 4500;
  localparam longint      BMAX   = 65535;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tarjeta_recibida = 1'b0;
  logic        tipo_trans = 1'b0;
  logic        digito_stb = 1'b0;
  logic [3:0]  digito = 4'd0;
  logic        monto_stb = 1'b0;
  logic [15:0] monto = 16'd0;
  logic        balance_actualizado;
  logic        entregar_dinero;
  logic        pin_incorrecto;
  logic        advertencia;
  logic        bloqueo;
  logic        fondos_insuficientes;
  logic [15:0] balance;
  logic [2:0]  estado;

  always #5 clk = ~clk;

  atm_controller_param #(
    .PIN_DIGITS   (4),
    .PIN_CODE     (16'h4756),
    .MAX_ATTEMPTS (3),
    .BAL_W        (16),
    .MONTO_W      (16),
    .INIT_BALANCE (16'd4500),
    .TIMEOUT_CYC  (16)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .tarjeta_recibida     (tarjeta_recibida),
    .tipo_trans           (tipo_trans),
    .digito_stb           (digito_stb),
    .digito               (digito),
    .monto_stb            (monto_stb),
    .monto                (monto),
    .balance_actualizado  (balance_actualizado),
    .entregar_dinero      (entregar_dinero),
    .pin_incorrecto       (pin_incorrecto),
    .advertencia          (advertencia),
    .bloqueo              (bloqueo),
    .fondos_insuficientes (fondos_insuficientes),
    .balance              (balance),
    .estado               (estado)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Pulse counters, sampled mid-cycle.
  int n_upd = 0, n_disp = 0, n_pin = 0, n_nsf = 0;
  always @(negedge clk) begin
    if (balance_actualizado)  n_upd++;
    if (entregar_dinero)      n_disp++;
    if (pin_incorrecto)       n_pin++;
    if (fondos_insuficientes) n_nsf++;
  end

  // Session-level reference model.
  longint bal_m;
  int     att_m;
  bit     locked_m;
  int     exp_st;

  logic [15:0] code_v;
  int          tries;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tarjeta_recibida = 1'b0;
    digito_stb = 1'b0;
    monto_stb = 1'b0;
    tick();
    chk("rst_estado", 64'(estado), 64'd0);
    chk("rst_balance", 64'(balance), 64'(BAL0));
    chk("rst_flags", 64'({balance_actualizado, entregar_dinero, pin_incorrecto,
                          advertencia, bloqueo, fondos_insuficientes}), 64'd0);
    rst = 1'b0;
    bal_m = BAL0;
    att_m = 0;
    locked_m = 1'b0;
    exp_st = 0;
  endtask

  task automatic card();
    tarjeta_recibida = 1'b1;
    tick();
    tarjeta_recibida = 1'b0;
    exp_st = locked_m ? 5 : 1;
    chk("card_estado", 64'(estado), 64'(exp_st));
  endtask

  task automatic enter_digits(input logic [15:0] code, input int n);
    for (int i = 0; i < n; i++) begin
      digito = code[15 - 4*i -: 4];
      digito_stb = 1'b1;
      tick();
      digito_stb = 1'b0;
      if (i < n - 1) repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic attempt_pin(input logic [15:0] code);
    int w = 0;
    bit wrong;
    enter_digits(code, 4);
    // One more PIN cycle before CHECK; a strobe there must be ignored.
    while (estado == 3'd1 && w < 10) begin
      if (w == 0) begin
        digito_stb = 1'($urandom_range(0, 1));
        digito = 4'($urandom_range(0, 15));
      end
      tick();
      digito_stb = 1'b0;
      w++;
    end
    chk("pin_to_check_cycles", 64'(w), 64'd1);
    chk("check_estado", 64'(estado), 64'd2);
    tick();
    wrong = (code != PIN_OK);
    if (!wrong) begin
      att_m = 0;
      exp_st = tipo_trans ? 4 : 3;
    end else begin
      att_m++;
      if (att_m == MAXA) begin
        locked_m = 1'b1;
        exp_st = 5;
      end else begin
        exp_st = 1;
      end
    end
    chk("post_check_estado", 64'(estado), 64'(exp_st));
    chk("pin_incorrecto", 64'(pin_incorrecto), 64'(wrong));
    chk("advertencia", 64'(advertencia), 64'(!locked_m && att_m == MAXA - 1));
    chk("bloqueo", 64'(bloqueo), 64'(locked_m));
    tick();
    chk("pin_incorrecto_width", 64'(pin_incorrecto), 64'd0);
    chk("hold_estado", 64'(estado), 64'(exp_st));
  endtask

  task automatic transact(input logic [15:0] amt);
    bit e_upd, e_disp, e_nsf;
    longint s;
    repeat ($urandom_range(0, 4)) tick();
    monto = amt;
    monto_stb = 1'b1;
    digito_stb = 1'($urandom_range(0, 1));
    tick();
    monto_stb = 1'b0;
    digito_stb = 1'b0;
    e_upd = 1'b0; e_disp = 1'b0; e_nsf = 1'b0;
    if (exp_st == 3) begin
      s = bal_m + longint'(amt);
      bal_m = (s > BMAX) ? BMAX : s;
      e_upd = 1'b1;
    end else if (longint'(amt) > bal_m) begin
      e_nsf = 1'b1;
    end else begin
      bal_m = bal_m - longint'(amt);
      e_upd = 1'b1;
      e_disp = 1'b1;
    end
    exp_st = 0;
    chk("txn_estado", 64'(estado), 64'd0);
    chk("txn_balance", 64'(balance), 64'(bal_m));
    chk("balance_actualizado", 64'(balance_actualizado), 64'(e_upd));
    chk("entregar_dinero", 64'(entregar_dinero), 64'(e_disp));
    chk("fondos_insuficientes", 64'(fondos_insuficientes), 64'(e_nsf));
    tick();
    chk("txn_pulse_width", 64'({balance_actualizado, entregar_dinero,
                                fondos_insuficientes}), 64'd0);
  endtask

  task automatic wait_timeout(input string tag, input int exp_n);
    int n = 0;
    int p0 = n_upd + n_disp + n_pin + n_nsf;
    while (estado != 3'd0 && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 64'(n), 64'(exp_n));
    tick();
    chk("timeout_no_pulses", 64'(n_upd + n_disp + n_pin + n_nsf - p0), 64'd0);
    chk("timeout_balance", 64'(balance), 64'(bal_m));
    exp_st = 0;
  endtask

  task automatic check_locked();
    card();
    enter_digits(PIN_OK, 4);
    repeat (3) tick();
    chk("locked_estado", 64'(estado), 64'd5);
    chk("locked_bloqueo", 64'(bloqueo), 64'd1);
    chk("locked_advertencia", 64'(advertencia), 64'd0);
    chk("locked_balance", 64'(balance), 64'(bal_m));
  endtask

  function automatic logic [15:0] pick_amt();
    int r = int'($urandom_range(0, 9));
    case (r)
      0:       return 16'd0;
      1:       return 16'(bal_m);
      2:       return (bal_m < BMAX) ? 16'(bal_m + 1) : 16'(bal_m);
      3:       return 16'($urandom_range(60000, 65535));
      default: return 16'($urandom_range(0, 3000));
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    apply_reset();

    // Happy deposit.
    tipo_trans = 1'b0;
    card();
    attempt_pin(PIN_OK);
    transact(16'd500);
    chk("deposit_5000", 64'(balance), 64'd5000);

    // Withdrawal then insufficient funds.
    apply_reset();
    tipo_trans = 1'b1;
    card();
    attempt_pin(PIN_OK);
    transact(16'd1000);
    chk("withdraw_3500", 64'(balance), 64'd3500);
    card();
    attempt_pin(PIN_OK);
    transact(16'd4000);
    chk("nsf_keeps_3500", 64'(balance), 64'd3500);

    // Attempt counter cleared by a correct PIN.
    tipo_trans = 1'b0;
    card();
    attempt_pin(16'h1111);
    attempt_pin(16'h1111);
    attempt_pin(PIN_OK);
    transact(16'd0);
    card();
    attempt_pin(16'h1111);
    attempt_pin(16'h1111);
    attempt_pin(PIN_OK);
    transact(16'd0);

    // Timeout mid-PIN keeps the attempt count across sessions.
    card();
    attempt_pin(16'h1111);
    wait_timeout("pin_retry_timeout", 15);
    card();
    enter_digits(PIN_OK, 2);
    wait_timeout("digit_timeout", 16);
    card();
    attempt_pin(16'h1111);
    chk("warn_after_timeout", 64'(advertencia), 64'd1);
    attempt_pin(16'h1111);
    check_locked();
    apply_reset();

    // Three wrong PINs in one session.
    card();
    attempt_pin(16'h1111);
    attempt_pin(16'h1111);
    attempt_pin(16'h1111);
    chk("lockout_estado", 64'(estado), 64'd5);
    check_locked();
    apply_reset();

    // Saturating deposit.
    card();
    attempt_pin(PIN_OK);
    transact(16'd65000);
    chk("saturate_65535", 64'(balance), 64'd65535);

    // Transaction timeout, then reset while in WITHDRAW.
    tipo_trans = 1'b1;
    card();
    attempt_pin(PIN_OK);
    wait_timeout("txn_timeout", 15);
    card();
    attempt_pin(PIN_OK);
    chk("in_withdraw", 64'(estado), 64'd4);
    apply_reset();

    // Randomized sessions.
    for (int s = 0; s < 60; s++) begin
      if (locked_m) begin
        check_locked();
        apply_reset();
      end
      tipo_trans = 1'($urandom_range(0, 1));
      card();
      tries = 0;
      do begin
        code_v = ($urandom_range(0, 3) != 0) ? PIN_OK : 16'($urandom);
        attempt_pin(code_v);
        tries++;
      end while (exp_st == 1 && $urandom_range(0, 2) != 0 && tries < 4);
      if (exp_st == 1) begin
        wait_timeout("rand_pin_timeout", 15);
      end else if (exp_st == 3 || exp_st == 4) begin
        if ($urandom_range(0, 7) == 0) wait_timeout("rand_txn_timeout", 15);
        else transact(pick_amt());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
